// File: rtl/simple_bus_slave.sv
// Memory-backed simple_bus slave: registered req/gnt tenure, one 8-bit-addressed
// READ/WRITE/INC per accepted start, completing with a one-cycle rdy pulse.
module simple_bus_slave (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] addr,
  input  logic [1:0] mode,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       gnt,
  output logic       rdy,
  output logic [7:0] data_out,
  output logic       data_oe
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] MODE_READ  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_INC   = 2'b10;

  state_t     state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       rdy_q, rdy_d;
  logic       oe_q, oe_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] addr_q, addr_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] mem_q [256];
  logic [7:0] mem_d [256];

  // Handshake: start is taken only when the registered grant is high and no
  // operation is in flight; the operation retires on the very next edge.
  always_comb begin
    state_d = state_q;
    gnt_d   = req & (state_q == ST_IDLE);
    rdy_d   = 1'b0;
    oe_d    = 1'b0;
    dout_d  = dout_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    wdata_d = wdata_q;
    mem_d   = mem_q;
    case (state_q)
      ST_IDLE: begin
        if (start && gnt_q) begin
          addr_d  = addr;
          mode_d  = mode;
          wdata_d = data_in;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        state_d = ST_IDLE;
        rdy_d   = 1'b1;
        case (mode_q)
          MODE_READ: begin
            dout_d = mem_q[addr_q];
            oe_d   = 1'b1;
          end
          MODE_WRITE: begin
            mem_d[addr_q] = wdata_q;
          end
          MODE_INC: begin
            mem_d[addr_q] = mem_q[addr_q] + 8'd1;
            dout_d        = mem_q[addr_q];
            oe_d          = 1'b1;
          end
          default: begin
            dout_d = 8'h00;
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      rdy_q   <= 1'b0;
      oe_q    <= 1'b0;
      dout_q  <= 8'h00;
      addr_q  <= 8'h00;
      mode_q  <= 2'b00;
      wdata_q <= 8'h00;
      for (int i = 0; i < 256; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rdy_q   <= rdy_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      wdata_q <= wdata_d;
      for (int i = 0; i < 256; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign gnt      = gnt_q;
  assign rdy      = rdy_q;
  assign data_out = dout_q;
  assign data_oe  = oe_q;

endmodule

// File: tb/tb_simple_bus_slave.sv
// Bench for simple_bus_slave: directed protocol cases plus random traffic,
// checked by a queue-based scoreboard fed from a behavioural model.
module tb_simple_bus_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [7:0] addr;
  logic [1:0] mode;
  logic       start;
  logic [7:0] data_in;
  logic       gnt;
  logic       rdy;
  logic [7:0] data_out;
  logic       data_oe;

  always #5 clk = ~clk;

  simple_bus_slave dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .addr     (addr),
    .mode     (mode),
    .start    (start),
    .data_in  (data_in),
    .gnt      (gnt),
    .rdy      (rdy),
    .data_out (data_out),
    .data_oe  (data_oe)
  );

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tenure and one-cycle transactions, memory as a plain array.
  logic [7:0] m_mem [256];
  bit         m_busy = 1'b0;
  bit         m_gnt = 1'b0;
  bit         m_rdy = 1'b0;
  logic [7:0] m_dout = 8'h00;
  bit         p_wr = 1'b0;
  logic [7:0] p_addr = 8'h00;
  logic [7:0] p_data = 8'h00;
  bit         was_busy;
  bit         acc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
      m_busy = 1'b0;
      m_gnt  = 1'b0;
      m_rdy  = 1'b0;
      m_dout = 8'h00;
      p_wr   = 1'b0;
      exp_q.delete();
    end else begin
      was_busy = m_busy;
      acc      = start && m_gnt && !m_busy;
      m_rdy    = was_busy;
      if (was_busy) begin
        if (p_wr) m_mem[p_addr] = p_data;
        p_wr   = 1'b0;
        m_busy = 1'b0;
      end
      m_gnt = req && !was_busy;
      if (acc) begin
        m_busy = 1'b1;
        case (mode)
          2'b00: begin
            m_dout = m_mem[addr];
            exp_q.push_back({1'b1, m_dout});
          end
          2'b01: begin
            p_wr = 1'b1; p_addr = addr; p_data = data_in;
            exp_q.push_back({1'b0, m_dout});
          end
          2'b10: begin
            p_wr = 1'b1; p_addr = addr; p_data = m_mem[addr] + 8'd1;
            m_dout = m_mem[addr];
            exp_q.push_back({1'b1, m_dout});
          end
          default: begin
            m_dout = 8'h00;
            exp_q.push_back({1'b0, 8'h00});
          end
        endcase
      end
    end
  end

  // Monitor: grant and rdy every cycle; response popped whenever rdy is seen.
  always @(negedge clk) begin
    check("gnt", {8'h00, gnt}, {8'h00, m_gnt});
    check("rdy", {8'h00, rdy}, {8'h00, m_rdy});
    if (rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected actual=%0h expected=none at %0t", {data_oe, data_out}, $time);
      end else begin
        check("resp", {data_oe, data_out}, exp_q.pop_front());
      end
    end else begin
      check("oe_idle", {8'h00, data_oe}, 9'h000);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_gnt();
    int n = 0;
    req = 1'b1;
    while (gnt !== 1'b1 && n < 10) begin
      step(1);
      n++;
    end
    if (gnt !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL gnt_timeout actual=%0b expected=1 at %0t", gnt, $time);
    end
  endtask

  // One transaction; inputs are scrambled after acceptance, and hold keeps
  // start asserted into the busy cycle.
  task automatic txn(input logic [1:0] m, input logic [7:0] a, input logic [7:0] d, input bit hold);
    start = 1'b0; addr = a; mode = m; data_in = d;
    wait_gnt();
    start = 1'b1;
    step(1);
    if (!hold) start = 1'b0;
    addr = 8'($urandom); mode = 2'($urandom); data_in = 8'($urandom);
    step(1);
    start = 1'b0;
    step(1);
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; start = 1'b0; addr = 8'h00; mode = 2'b00; data_in = 8'h00;
    #1 rst = 1'b1;
    step(3);
    rst = 1'b0;
    check("dout_reset", {1'b0, data_out}, 9'h000);
    txn(2'b00, 8'h77, 8'h00, 1'b0);

    // Reset asserted mid-cycle during a READ's rdy cycle.
    txn(2'b01, 8'h20, 8'h9A, 1'b0);
    addr = 8'h20; mode = 2'b00; start = 1'b0;
    wait_gnt();
    start = 1'b1;
    step(1);
    start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_gnt", {8'h00, gnt}, 9'h000);
    check("rst_rdy", {8'h00, rdy}, 9'h000);
    check("rst_oe", {8'h00, data_oe}, 9'h000);
    step(1);
    rst = 1'b0;
    txn(2'b00, 8'h20, 8'h00, 1'b0);

    txn(2'b01, 8'h3C, 8'hA5, 1'b0);
    txn(2'b00, 8'h3C, 8'h00, 1'b0);
    txn(2'b01, 8'h00, 8'hFF, 1'b0);
    txn(2'b10, 8'h00, 8'h00, 1'b0);
    txn(2'b00, 8'h00, 8'h00, 1'b0);

    // start without tenure, start held into busy, reserved mode.
    req = 1'b0; start = 1'b0;
    step(3);
    addr = 8'h3C; mode = 2'b01; data_in = 8'h11; start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    txn(2'b01, 8'h3C, 8'h22, 1'b1);
    txn(2'b11, 8'h3C, 8'h33, 1'b0);
    txn(2'b00, 8'h3C, 8'h00, 1'b0);

    // Abort a WRITE by reset in its busy cycle.
    addr = 8'h10; mode = 2'b01; data_in = 8'h55; start = 1'b0;
    wait_gnt();
    start = 1'b1;
    step(1);
    start = 1'b0;
    #2 rst = 1'b1;
    step(1);
    rst = 1'b0;
    txn(2'b00, 8'h10, 8'h00, 1'b0);
    txn(2'b00, 8'h3C, 8'h00, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      req     = ($urandom_range(0, 3) != 0);
      start   = ($urandom_range(0, 2) == 0);
      addr    = 8'($urandom_range(0, 7));
      mode    = 2'($urandom_range(0, 3));
      data_in = 8'($urandom);
      step(1);
    end
    req = 1'b0; start = 1'b0;
    step(4);
    for (int a = 0; a < 8; a++) txn(2'b00, 8'(a), 8'h00, 1'b0);

    req = 1'b0;
    step(4);
    check("queue_drained", 9'(exp_q.size()), 9'h000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
